// File: rtl/simon_input_checker.sv
// simon_input_checker: debounces raw Simon buttons into single colour presses and checks them against the round's sequence
module simon_input_checker #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       start,
  input  logic [4:0] seq_len,
  input  logic [1:0] exp_color,
  output logic [3:0] rd_idx,
  input  logic [3:0] btn_n,
  output logic       busy,
  output logic       press_valid,
  output logic [1:0] press_color,
  output logic       pass,
  output logic       fail
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, PASS, FAIL} state_t;
  state_t state, state_n;
  logic [3:0] s1, s2, deb, deb_q, rise, idx_n;
  logic [4:0] len_q, len_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [1:0] color, pc_n;
  logic single, last, bad_len, pv_n;
  always_ff @(posedge CLOCK_50)
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      deb_q <= '0;
    end else begin
      s1 <= ~btn_n;
      s2 <= s1;
      deb_q <= deb;
    end
  // each debouncer counts consecutive cycles of disagreement and flips on the last one
  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic [DW-1:0] cnt;
    logic d;
    always_ff @(posedge CLOCK_50)
      if (!reset_n) begin
        cnt <= '0;
        d <= 1'b0;
      end else if (s2[i] == d) cnt <= '0;
      else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        d <= s2[i];
      end else cnt <= cnt + 1'b1;
    assign deb[i] = d;
  end
  assign rise = deb & ~deb_q;
  assign single = (rise != 4'd0) && ((rise & (rise - 4'd1)) == 4'd0);
  assign color = {rise[3] | rise[2], rise[3] | rise[1]};
  assign last = ({1'b0, rd_idx} == len_q - 5'd1);
  assign bad_len = (seq_len == 5'd0) || (int'(seq_len) > MAX_LEN);
  always_comb begin
    state_n = state;
    idx_n = rd_idx;
    len_n = len_q;
    tcnt_n = tcnt;
    pv_n = 1'b0;
    pc_n = press_color;
    case (state)
      IDLE:
        if (start) begin
          len_n = seq_len;
          if (bad_len) state_n = FAIL;
          else begin
            idx_n = 4'd0;
            tcnt_n = '0;
            state_n = WAIT_PRESS;
          end
        end
      WAIT_PRESS:
        if (single) begin
          pv_n = 1'b1;
          pc_n = color;
          if (color != exp_color) state_n = FAIL;
          else if (last) state_n = PASS;
          else begin
            idx_n = rd_idx + 4'd1;
            state_n = WAIT_RELEASE;
          end
        end else if (rise != 4'd0) state_n = FAIL;
        else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) state_n = FAIL;
        else tcnt_n = tcnt + 1'b1;
      WAIT_RELEASE:
        if (deb == 4'd0) begin
          tcnt_n = '0;
          state_n = WAIT_PRESS;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50)
    if (!reset_n) begin
      state <= IDLE;
      rd_idx <= '0;
      len_q <= '0;
      tcnt <= '0;
      press_valid <= 1'b0;
      press_color <= '0;
    end else begin
      state <= state_n;
      rd_idx <= idx_n;
      len_q <= len_n;
      tcnt <= tcnt_n;
      press_valid <= pv_n;
      press_color <= pc_n;
    end
  assign busy = (state != IDLE);
  assign pass = (state == PASS);
  assign fail = (state == FAIL);
endmodule

// File: tb/tb_simon_input_checker.sv
// tb_simon_input_checker: directed checks of debounce latency, round pass/fail, timeout and reset abort
module tb_simon_input_checker;
  logic clk = 1'b0;
  logic reset_n, start;
  logic [4:0] seq_len;
  logic [1:0] exp_color;
  logic [3:0] rd_idx;
  logic [3:0] btn_n;
  logic busy, press_valid, pass, fail;
  logic [1:0] press_color;
  logic [1:0] mem [16];
  int errors = 0, checks = 0;
  int pv_cnt = 0, pass_cnt = 0, fail_cnt = 0, both_cnt = 0;
  int pv0, pass0, fail0;
  simon_input_checker #(.DEBOUNCE_CYCLES(2), .MAX_LEN(16), .TIMEOUT_CYCLES(50)) dut (
    .CLOCK_50(clk), .reset_n(reset_n), .start(start), .seq_len(seq_len),
    .exp_color(exp_color), .rd_idx(rd_idx), .btn_n(btn_n), .busy(busy),
    .press_valid(press_valid), .press_color(press_color), .pass(pass), .fail(fail)
  );
  always #5 clk = ~clk;
  assign exp_color = mem[rd_idx];
  always @(negedge clk) begin
    if (press_valid === 1'b1) pv_cnt++;
    if (pass === 1'b1) pass_cnt++;
    if (fail === 1'b1) fail_cnt++;
    if (pass === 1'b1 && fail === 1'b1) both_cnt++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [4:0] n);
    start = 1'b1;
    seq_len = n;
    tick();
    start = 1'b0;
  endtask
  task automatic press(input int c);
    btn_n[c] = 1'b0;
    repeat (6) tick();
    btn_n = 4'hF;
    repeat (6) tick();
  endtask
  // press with exact-latency checks: press_valid must appear on the 5th edge after the fall
  task automatic press_lat(input int c, input logic [3:0] idx_after, input logic exp_pass);
    btn_n[c] = 1'b0;
    repeat (4) tick();
    check("pv_early", press_valid, 0);
    tick();
    check("pv_on", press_valid, 1);
    check("press_color", press_color, c);
    check("rd_idx_step", rd_idx, idx_after);
    check("pass_at_press", pass, exp_pass);
    tick();
    check("pv_single", press_valid, 0);
    if (exp_pass) check("busy_after_pass", busy, 0);
    btn_n = 4'hF;
    repeat (6) tick();
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;
    reset_n = 1'b0;
    start = 1'b0;
    seq_len = 5'd0;
    btn_n = 4'hF;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_pv", press_valid, 0);
    check("rst_color", press_color, 0);
    check("rst_pass", pass, 0);
    check("rst_fail", fail, 0);
    check("rst_idx", rd_idx, 0);
    reset_n = 1'b1;
    tick();
    btn_n[1] = 1'b0;
    tick();
    btn_n = 4'hF;
    repeat (8) tick();
    check("glitch_ignored", pv_cnt, 0);
    // correct 3-press round
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
    pass0 = pass_cnt;
    go(5'd3);
    check("r1_busy", busy, 1);
    check("r1_idx0", rd_idx, 0);
    press_lat(2, 4'd1, 1'b0);
    press_lat(0, 4'd2, 1'b0);
    press_lat(3, 4'd2, 1'b1);
    check("r1_pv_count", pv_cnt, 3);
    check("r1_pass_count", pass_cnt, pass0 + 1);
    check("r1_no_fail", fail_cnt, 0);
    // wrong colour on second press
    mem[0] = 2'd1; mem[1] = 2'd1;
    pass0 = pass_cnt;
    fail0 = fail_cnt;
    go(5'd2);
    press(1);
    btn_n[2] = 1'b0;
    repeat (5) tick();
    check("wc_pv", press_valid, 1);
    check("wc_color", press_color, 2);
    check("wc_fail", fail, 1);
    check("wc_pass", pass, 0);
    btn_n = 4'hF;
    repeat (6) tick();
    check("wc_no_pass", pass_cnt, pass0);
    check("wc_fail_count", fail_cnt, fail0 + 1);
    check("wc_idle", busy, 0);
    // two buttons together
    pv0 = pv_cnt;
    fail0 = fail_cnt;
    go(5'd2);
    btn_n = 4'b0110;
    repeat (5) tick();
    check("mp_pv", press_valid, 0);
    check("mp_fail", fail, 1);
    btn_n = 4'hF;
    repeat (6) tick();
    check("mp_pv_count", pv_cnt, pv0);
    check("mp_fail_count", fail_cnt, fail0 + 1);
    // second button added while first is held is ignored
    mem[0] = 2'd1; mem[1] = 2'd2;
    pv0 = pv_cnt;
    pass0 = pass_cnt;
    go(5'd2);
    btn_n[1] = 1'b0;
    repeat (6) tick();
    btn_n[2] = 1'b0;
    repeat (6) tick();
    check("wr_pv_count", pv_cnt, pv0 + 1);
    check("wr_no_pass", pass_cnt, pass0);
    btn_n[1] = 1'b1;
    repeat (6) tick();
    check("wr_still_busy", busy, 1);
    check("wr_pv_hold", pv_cnt, pv0 + 1);
    btn_n = 4'hF;
    repeat (6) tick();
    press(2);
    check("wr_pass", pass_cnt, pass0 + 1);
    check("wr_pv_total", pv_cnt, pv0 + 2);
    // timeout
    go(5'd3);
    repeat (49) tick();
    check("to_not_yet", fail, 0);
    tick();
    check("to_fail", fail, 1);
    tick();
    check("to_idle", busy, 0);
    // illegal lengths
    go(5'd0);
    check("len0_fail", fail, 1);
    tick();
    check("len0_idle", busy, 0);
    go(5'd17);
    check("len17_fail", fail, 1);
    tick();
    // full-length round
    for (int i = 0; i < 16; i++) mem[i] = 2'((i * 3 + 1) % 4);
    pv0 = pv_cnt;
    pass0 = pass_cnt;
    fail0 = fail_cnt;
    go(5'd16);
    check("ml_busy", busy, 1);
    for (int i = 0; i < 16; i++) press((i * 3 + 1) % 4);
    check("ml_pass", pass_cnt, pass0 + 1);
    check("ml_no_fail", fail_cnt, fail0);
    check("ml_pv_count", pv_cnt, pv0 + 16);
    check("ml_idx_hold", rd_idx, 15);
    // reset mid-round
    mem[0] = 2'd0; mem[1] = 2'd1; mem[2] = 2'd2; mem[3] = 2'd3;
    pass0 = pass_cnt;
    fail0 = fail_cnt;
    go(5'd4);
    press(0);
    press(1);
    check("rs_idx2", rd_idx, 2);
    reset_n = 1'b0;
    tick();
    check("rs_busy", busy, 0);
    check("rs_idx", rd_idx, 0);
    reset_n = 1'b1;
    repeat (3) tick();
    check("rs_no_pass", pass_cnt, pass0);
    check("rs_no_fail", fail_cnt, fail0);
    go(5'd2);
    check("rs_new_busy", busy, 1);
    check("rs_new_idx", rd_idx, 0);
    press(0);
    press(1);
    check("rs_new_pass", pass_cnt, pass0 + 1);
    check("never_both", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
